inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Fetch-side buffer directly downstream of the PC register. It pairs each issued PC with the instruction word returned one cycle later by the synchronous instruction ROM, and holds the pairs in a small in-order queue for the decode stage. Decode uses a valid/ready handshake. When the queue overflows because decode stalls, the block requests a replay. The PC register has no stall input; the replay loads the dropped PC back into it through its jump path. A branch redirect flushes the queue.

## Interface
- `DEPTH`, default 4: queue entries; power of two, ≥2.
- `ADDR_W`, default 32: PC width.
- `DATA_W`, default 32: instruction width.

- `clk_i`  in  1  single clock; all state updates on posedge.
- `rst_i`  in  1  synchronous, active-high reset.
- `pc_i`  in  ADDR_W  PC currently presented to ROM (from PC register).
- `ce_i`  in  1  PC register chip enable; 1 = `pc_i` is a real request.
- `inst_i`  in  DATA_W  ROM read data; valid for the request presented in the previous cycle.
- `flush_i`  in  1  branch/jump redirect, the same cycle the PC register jump enable is sampled.
- `ready_i`  in  1  decode accepts head entry this cycle.
- `valid_o`  out  1  head entry valid.
- `inst_o`  out  DATA_W  head instruction; 0 when empty.
- `inst_addr_o`  out  ADDR_W  head PC; 0 when empty.
- `replay_o`  out  1  one-cycle replay request; ORed into PC register jump enable at top level.
- `replay_addr_o`  out  ADDR_W  PC to reload; muxed to jump address when `replay_o`=1 and no branch.

## Operation
- In-flight register: each posedge captures `req_pc_q` ← `pc_i` and `req_v_q` ← `ce_i & ~flush_i`. The pair (`req_pc_q`, `inst_i`) is the candidate entry in the following cycle.
- Queue: circular buffer of DEPTH entries. Read and write pointers are log2(DEPTH) bits and wrap naturally; the count is log2(DEPTH)+1 bits. Head is show-ahead: `valid_o` = count≠0.
- Dequeue when `valid_o & ready_i`.
- Enqueue is allowed only when count<DEPTH before this cycle's dequeue. There is no full-bypass.
- State machine:
  - RUN: a valid candidate with space is enqueued. A valid candidate with no space is dropped; the block sets `replay_addr_o` ← `req_pc_q`, pulses `replay_o` next cycle, and goes to WAIT.
  - WAIT: candidates with `req_pc_q` ≠ `replay_addr_o` are discarded (stale sequential fetches). A candidate with `req_pc_q` = `replay_addr_o` is handled as in RUN: enqueued and return to RUN if there is space; otherwise dropped again, `replay_o` re-pulsed, and the block stays in WAIT.
- `flush_i`=1 at a posedge:
  - queue emptied (pointers and count ← 0);
  - `req_v_q` ← 0, killing the wrong-path request;
  - state ← RUN;
  - `replay_o` ← 0;
  - any candidate present that cycle is discarded and its dequeue is ignored.
- Priority: reset > flush > replay/enqueue/dequeue.
- Branch and replay in the same cycle: the top level gives the branch priority, and the block cancels the replay through `flush_i`.
- `ce_i`=0 (PC register in reset): no candidate is produced.

## Timing
- Reset values: `valid_o`=0, `inst_o`=0, `inst_addr_o`=0, `replay_o`=0, `replay_addr_o`=0. Also cleared: queue empty, `req_v_q`=0, state RUN.
- Fetch latency: PC P presented in cycle N → `inst_i` in N+1 → enqueued at end of N+1 → `valid_o`=1 in N+2 if the queue was empty.
- Replay: drop detected in cycle N+1 → `replay_o`=1 during N+2 only → PC register holds P in N+3 → P candidate in N+4 (enqueued if space).
- Simultaneous enqueue and dequeue with 0<count<DEPTH: count unchanged.
- At count=DEPTH with dequeue: the dequeue happens and the same-cycle candidate is still dropped (replay issued).
- Reset asserted mid-operation (any state, queue occupied) returns everything to the reset values at the next posedge. In-flight data is discarded.

## Test plan
- Streaming:
  - Stimulus: `ready_i`=1; PCs 0x0, 0x4, 0x8…; ROM returns PC+0x100.
  - Required: from the second cycle after the first request, `valid_o` stays high and `inst_o`/`inst_addr_o` step 0x100/0x0, 0x104/0x4… with no gaps and no `replay_o`.
- Overflow and replay (DEPTH=4):
  - Stimulus: hold `ready_i`=0 until four entries (0x0–0xC) are queued; the 0x10 candidate arrives.
  - Required: single `replay_o` pulse with `replay_addr_o`=0x10; stale 0x14/0x18 candidates discarded. After `ready_i`=1 and the PC reload, order out is 0x0, 0x4, 0x8, 0xC, 0x10 exactly once each.
- Repeated drop:
  - Stimulus: keep `ready_i`=0 through the replayed 0x10 candidate.
  - Required: second `replay_o` pulse with `replay_addr_o`=0x10; state remains WAIT.
- Flush:
  - Stimulus: three entries queued and a request in flight; `flush_i`=1 with jump target 0x200.
  - Required: `valid_o`=0 the next cycle; the first entry out is 0x200; no pre-flush PC is ever delivered.
- Flush during WAIT:
  - Stimulus: `flush_i` in the same cycle `replay_o` would fire.
  - Required: `replay_o` stays 0, state returns to RUN, the jump-target stream is delivered.
- Reset mid-run:
  - Stimulus: assert `rst_i` with a full queue.
  - Required: all outputs 0 the next cycle; after release, delivery restarts from the PC register's reset address.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//
// Fetch-side buffer placed after the PC register. Each PC presented to the
// synchronous instruction ROM is held for one cycle. It is then paired with the
// returned instruction word and pushed into a small in-order show-ahead queue
// that feeds decode.
//
// The PC register cannot stall. If a fetched pair finds the queue full, the
// pair is dropped and a one-cycle replay request reloads the PC register with
// the dropped address. Sequential fetches that were already in flight are then
// discarded until the replayed address comes back. A branch redirect
// (flush_i) empties the queue and kills the request that is in flight.
//
// Ports
//   clk_i          clock, all state updates on posedge
//   rst_i          synchronous active-high reset
//   pc_i           PC currently presented to the ROM
//   ce_i           1 = pc_i is a real request
//   inst_i         ROM data for the request presented last cycle
//   flush_i        branch/jump redirect
//   ready_i        decode accepts the head entry
//   valid_o        head entry valid
//   inst_o         head instruction (0 when empty)
//   inst_addr_o    head PC (0 when empty)
//   replay_o       one-cycle request to reload the PC register
//   replay_addr_o  PC to reload
module inst_fetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic              flush_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              replay_o,
    output logic [ADDR_W-1:0] replay_addr_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    localparam logic [0:0] StRun  = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    // In-flight request register.
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              req_v_q, req_v_d;

    // Queue state.
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [DATA_W-1:0] inst_mem_q [DEPTH];
    logic [DATA_W-1:0] inst_mem_d [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_d [DEPTH];

    // Control state.
    logic [0:0]        state_q, state_d;
    logic              replay_q, replay_d;
    logic [ADDR_W-1:0] replay_addr_q, replay_addr_d;

    logic has_space;
    logic deq;
    logic take;
    logic enq;
    logic drop;

    // Space is judged on the count before this cycle's dequeue. No full-bypass.
    assign has_space = (count_q != FullCnt);
    assign deq       = valid_o & ready_i;

    // While waiting for a replay, only the replayed address is considered.
    // Everything else is a stale sequential fetch from before the reload.
    assign take = req_v_q & ((state_q == StRun) | (req_pc_q == replay_addr_q));
    assign enq  = take & has_space;
    assign drop = take & ~has_space;

    always_comb begin
        req_pc_d      = pc_i;
        req_v_d       = ce_i & ~flush_i;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inst_mem_d    = inst_mem_q;
        addr_mem_d    = addr_mem_q;
        state_d       = state_q;
        replay_d      = 1'b0;
        replay_addr_d = replay_addr_q;

        if (flush_i) begin
            // The candidate and the dequeue in this cycle are both ignored.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = StRun;
        end else begin
            if (enq) begin
                inst_mem_d[wr_ptr_q] = inst_i;
                addr_mem_d[wr_ptr_q] = req_pc_q;
                wr_ptr_d             = wr_ptr_q + PtrW'(1);
                state_d              = StRun;
            end
            if (drop) begin
                replay_d      = 1'b1;
                replay_addr_d = req_pc_q;
                state_d       = StWait;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(enq) - CntW'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_pc_q      <= '0;
            req_v_q       <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= StRun;
            replay_q      <= 1'b0;
            replay_addr_q <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            req_v_q       <= req_v_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            replay_q      <= replay_d;
            replay_addr_q <= replay_addr_d;
        end
    end

    // Storage needs no reset. The outputs are masked whenever the queue is
    // empty, so old contents are never visible.
    always_ff @(posedge clk_i) begin
        inst_mem_q <= inst_mem_d;
        addr_mem_q <= addr_mem_d;
    end

    always_comb begin
        valid_o     = (count_q != '0);
        inst_o      = '0;
        inst_addr_o = '0;
        if (valid_o) begin
            inst_o      = inst_mem_q[rd_ptr_q];
            inst_addr_o = addr_mem_q[rd_ptr_q];
        end
    end

    assign replay_o      = replay_q;
    assign replay_addr_o = replay_addr_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (DEPTH=4). A PC register model and a
// synchronous ROM (data = PC + 0x100) surround the DUT. The PC register takes
// a branch first, then a replay reload, and otherwise steps by 4.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_en;
    logic [31:0] br_target;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] rom_q;

    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        replay_o;
    logic [31:0] replay_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst)            pc <= 32'h0;
        else if (br_en)     pc <= br_target;
        else if (replay_o)  pc <= replay_addr_o;
        else                pc <= pc + 32'h4;
        rom_q <= pc + 32'h100;
    end

    inst_fetch_queue #(
        .DEPTH (4),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pc_i         (pc),
        .ce_i         (~rst),
        .inst_i       (rom_q),
        .flush_i      (br_en),
        .ready_i      (ready),
        .valid_o      (valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .replay_o     (replay_o),
        .replay_addr_o(replay_addr_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] addr);
        chk({tag, " valid"}, {31'b0, valid_o}, 32'h1);
        chk({tag, " addr"}, inst_addr_o, addr);
        chk({tag, " inst"}, inst_o, addr + 32'h100);
    endtask

    // Leaves the bench in cycle C0: pc=0 presented with ce=1, queue empty.
    task automatic restart();
        rst   = 1'b1;
        br_en = 1'b0;
        ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        br_en     = 1'b0;
        br_target = 32'h0;
        ready     = 1'b0;
        step();
        step();

        // Reset values
        chk("reset valid", {31'b0, valid_o}, 32'h0);
        chk("reset inst", inst_o, 32'h0);
        chk("reset addr", inst_addr_o, 32'h0);
        chk("reset replay", {31'b0, replay_o}, 32'h0);
        chk("reset replay_addr", replay_addr_o, 32'h0);

        // Streaming: head appears two cycles after the first request, no gaps
        rst   = 1'b0;
        ready = 1'b1;
        step();
        chk("stream C1 valid", {31'b0, valid_o}, 32'h0);
        step();
        for (int k = 0; k < 8; k++) begin
            chk_head("stream", 32'(4 * k));
            chk("stream replay", {31'b0, replay_o}, 32'h0);
            step();
        end

        // Overflow and replay. Decode stalls until the replay pulse.
        restart();
        repeat (5) step();                  // C5: queue full, 0x10 candidate
        chk_head("ovf C5 head", 32'h0);
        chk("ovf C5 replay", {31'b0, replay_o}, 32'h0);
        step();                             // C6
        chk("ovf replay pulse", {31'b0, replay_o}, 32'h1);
        chk("ovf replay addr", replay_addr_o, 32'h10);
        ready = 1'b1;
        // Stale 0x14 (C6) and 0x18 (C7, space free) must be discarded.
        for (int k = 0; k < 7; k++) begin
            chk_head("ovf order", 32'(4 * k));
            if (k != 0) chk("ovf single pulse", {31'b0, replay_o}, 32'h0);
            step();
        end

        // Repeated drop: decode stays stalled through the replayed 0x10
        restart();
        repeat (6) step();                  // C6
        chk("rep first pulse", {31'b0, replay_o}, 32'h1);
        step();
        chk("rep C7 replay", {31'b0, replay_o}, 32'h0);
        step();                             // C8: replayed 0x10 dropped again
        chk("rep C8 replay", {31'b0, replay_o}, 32'h0);
        step();                             // C9
        chk("rep second pulse", {31'b0, replay_o}, 32'h1);
        chk("rep second addr", replay_addr_o, 32'h10);
        step();                             // C10
        chk("rep C10 replay", {31'b0, replay_o}, 32'h0);
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk_head("rep order", 32'(4 * k));
            step();
        end

        // Flush with three entries queued and a request in flight
        restart();
        repeat (4) step();                  // C4
        chk_head("flush C4 head", 32'h0);
        br_en     = 1'b1;
        br_target = 32'h200;
        step();                             // C5
        br_en = 1'b0;
        ready = 1'b1;
        chk("flush valid", {31'b0, valid_o}, 32'h0);
        chk("flush inst", inst_o, 32'h0);
        chk("flush addr", inst_addr_o, 32'h0);
        step();                             // C6
        chk("flush C6 valid", {31'b0, valid_o}, 32'h0);
        step();                             // C7
        chk_head("flush target", 32'h200);
        step();
        chk_head("flush target+4", 32'h204);

        // Flush in the drop cycle cancels the replay
        restart();
        repeat (5) step();                  // C5: drop detected
        br_en     = 1'b1;
        br_target = 32'h300;
        step();                             // C6
        br_en = 1'b0;
        ready = 1'b1;
        chk("fw C6 replay", {31'b0, replay_o}, 32'h0);
        chk("fw C6 valid", {31'b0, valid_o}, 32'h0);
        step();                             // C7
        chk("fw C7 replay", {31'b0, replay_o}, 32'h0);
        chk("fw C7 valid", {31'b0, valid_o}, 32'h0);
        step();                             // C8
        chk_head("fw target", 32'h300);
        chk("fw C8 replay", {31'b0, replay_o}, 32'h0);
        step();
        chk_head("fw target+4", 32'h304);

        // Reset mid-run with a full queue and a drop pending
        restart();
        repeat (5) step();                  // C5
        chk_head("rst full head", 32'h0);
        rst = 1'b1;
        step();
        chk("rst valid", {31'b0, valid_o}, 32'h0);
        chk("rst inst", inst_o, 32'h0);
        chk("rst addr", inst_addr_o, 32'h0);
        chk("rst replay", {31'b0, replay_o}, 32'h0);
        chk("rst replay_addr", replay_addr_o, 32'h0);
        rst   = 1'b0;
        ready = 1'b1;
        step();
        step();
        chk_head("rst restart", 32'h0);
        step();
        chk_head("rst restart+4", 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
